rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
//  Shares one 8x8 ROM (3-bit address, active-high select, combinational 8-bit data)
//  among NREQ requesters. Round-robin arbitration; each grant runs a burst of 1..8
//  sequential reads with address wrap 7->0. Sits between requesters and the ROM
//  and is the only driver of the ROM's address/select pins.
// PARAMETERS
//  NREQ  2  number of requesters (2..4)
//  ID_W  1  width of rd_id; must satisfy 2**ID_W >= NREQ
// PORTS
//  clk       in   1       clock; all state on rising edge
//  rst_n     in   1       synchronous active-low reset
//  req       in   NREQ    per-requester request; hold high until own rd_last
//  req_addr  in   3*NREQ  start address, requester i in bits [3i+2:3i]
//  req_len   in   3*NREQ  burst length minus 1 (0 -> 1 word, 7 -> 8 words)
//  gnt       out  NREQ    one-hot grant; high for the whole burst of the owner
//  rd_valid  out  1       rd_data/rd_id/rd_last valid this cycle
//  rd_data   out  8       ROM word read
//  rd_id     out  ID_W    index of the requester that owns rd_data
//  rd_last   out  1       final word of the current burst
//  rom_addr  out  3       ROM address
//  rom_sel   out  1       ROM select, active high
//  rom_data  in   8       ROM data, combinational from rom_addr/rom_sel
// BEHAVIOUR
//  - All outputs are registered. Reset (rst_n low at an edge): state IDLE;
//    gnt, rd_valid, rd_last, rom_sel = 0; rd_data, rd_id, rom_addr = 0;
//    rr pointer = 0. Reset mid-burst aborts it; no further rd_valid is produced.
//  - FSM: IDLE, BURST.
//  - IDLE: rom_sel = 0. If req != 0 at edge T: winner = first set bit
//    searching ptr, ptr+1, ... (mod NREQ). Capture winner's req_addr/req_len,
//    set gnt[winner], go to BURST. ptr <= winner+1 mod NREQ.
//  - BURST, cycles T+1 .. T+1+len: rom_sel = 1, rom_addr = start+k (k = 0..len),
//    wrapping mod 8. The edge ending each issue cycle registers rom_data into
//    rd_data with rd_valid = 1 and rd_id = winner.
//    Data latency: word k valid in cycle T+2+k. rd_last = 1 with word len only.
//  - After the last issue cycle, return to IDLE; rom_sel = 0 in cycle T+2+len.
//    gnt stays high through cycle T+2+len, i.e. the rd_last cycle, then clears.
//  - IDLE arbitrates in the rd_last cycle, so back-to-back bursts issue with a
//    one-cycle bubble on rom_sel. Min request-to-first-data latency is 2 cycles.
//  - req, req_addr and req_len are sampled only in IDLE. Changes during BURST,
//    including req deassert by the owner, are ignored; the burst completes.
//  - Simultaneous requests: exactly one gnt bit is ever high; no starvation.
//    With all requesters continuously asserted, grants rotate 0,1,..,NREQ-1,0.
//  - rd_valid is 0 whenever no burst word is in flight; rd_data holds its last value.
// TESTING (ROM contents 0:E1 1:03 2:09 3:31 4:71 5:39 6:41 7:81)
//  1 Single read: req0=1, addr=3, len=0 at T -> gnt[0] in T+1..T+2; rom_sel in T+1;
//    rd_valid+rd_last, rd_data=0x31, rd_id=0 in T+2.
//  2 Wrap burst: req1, addr=6, len=3 -> rd_data 0x41,0x81,0xE1,0x03 in
//    consecutive cycles, rd_id=1, rd_last only with 0x03.
//  3 Full burst: req0, addr=0, len=7 -> eight words E1..81 in order, no gaps.
//  4 Contention: req=2'b11 held from reset release, both len=0 -> grant order
//    0,1,0,1; exactly one gnt bit high at any time; one idle rom_sel cycle between bursts.
//  5 Owner drop: req1 deasserted mid 4-word burst -> all 4 words still delivered.
//  6 Reset mid-burst: rst_n low during word 2 of an 8-word burst -> next cycle all
//    outputs 0; after release, req=2'b11 grants requester 0 first (ptr reset).

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one 8x8 combinational ROM among NREQ requesters. A round-robin
//   arbiter picks one requester in IDLE. That requester then receives a burst
//   of 1..8 sequential reads, and the address wraps from 7 to 0. This block is
//   the only driver of the ROM address and select pins. All outputs are
//   registered.
//
// Ports
//   i_clk       clock, all state on rising edge
//   i_rst_n     synchronous active-low reset
//   i_req       per-requester request, held until its own rd_last
//   i_req_addr  start address, requester i in [3i+2:3i]
//   i_req_len   burst length minus 1, requester i in [3i+2:3i]
//   o_gnt       one-hot grant, high for the whole burst including rd_last cycle
//   o_rd_valid  rd_data/rd_id/rd_last valid this cycle
//   o_rd_data   ROM word read
//   o_rd_id     index of the requester owning rd_data
//   o_rd_last   final word of the current burst
//   o_rom_addr  ROM address
//   o_rom_sel   ROM select, active high
//   i_rom_data  ROM data, combinational from rom_addr/rom_sel
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | rom_sel low; arbitrate among i_req (also the rd_last cycle)
// BURST  | rom_sel high; one ROM address issued per cycle until r_left == 0

module rom_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NREQ-1:0]     i_req,
  input  logic [3*NREQ-1:0]   i_req_addr,
  input  logic [3*NREQ-1:0]   i_req_len,
  output logic [NREQ-1:0]     o_gnt,
  output logic                o_rd_valid,
  output logic [7:0]          o_rd_data,
  output logic [ID_W-1:0]     o_rd_id,
  output logic                o_rd_last,
  output logic [2:0]          o_rom_addr,
  output logic                o_rom_sel,
  input  logic [7:0]          i_rom_data
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [2:0]        r_left;
  logic [NREQ-1:0]   r_gnt;
  logic              r_rd_valid;
  logic [7:0]        r_rd_data;
  logic [ID_W-1:0]   r_rd_id;
  logic              r_rd_last;
  logic [2:0]        r_rom_addr;
  logic              r_rom_sel;

  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_ptr_adv;
  logic [NREQ-1:0]   w_onehot;
  int                w_idx;

  logic [ID_W-1:0]   w_ptr_nxt;
  logic [ID_W-1:0]   w_owner_nxt;
  logic [2:0]        w_left_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic              w_rd_valid_nxt;
  logic [7:0]        w_rd_data_nxt;
  logic [ID_W-1:0]   w_rd_id_nxt;
  logic              w_rd_last_nxt;
  logic [2:0]        w_rom_addr_nxt;
  logic              w_rom_sel_nxt;

  // Round-robin search: first set request starting at r_ptr, wrapping mod NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(w_idx);
      end
    end
    if (int'(w_winner) == NREQ - 1) w_ptr_adv = '0;
    else                            w_ptr_adv = w_winner + ID_W'(1);
    for (int i = 0; i < NREQ; i++) w_onehot[i] = (int'(w_winner) == i);
  end

  // State register plus the registered outputs/datapath.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_left     <= '0;
      r_gnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_id    <= '0;
      r_rd_last  <= 1'b0;
      r_rom_addr <= '0;
      r_rom_sel  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_left     <= w_left_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_id    <= w_rd_id_nxt;
      r_rd_last  <= w_rd_last_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_rom_sel  <= w_rom_sel_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_state_nxt = ST_BURST;
      ST_BURST: if (r_left == 3'd0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. rd_data holds when no word is in
  // flight; gnt holds through BURST and is re-decided in IDLE, which is also
  // the rd_last cycle, so a new grant can follow with a single bubble.
  always_comb begin
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_left_nxt     = r_left;
    w_gnt_nxt      = r_gnt;
    w_rd_valid_nxt = 1'b0;
    w_rd_data_nxt  = r_rd_data;
    w_rd_id_nxt    = r_rd_id;
    w_rd_last_nxt  = 1'b0;
    w_rom_addr_nxt = r_rom_addr;
    w_rom_sel_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_gnt_nxt      = w_onehot;
          w_owner_nxt    = w_winner;
          w_ptr_nxt      = w_ptr_adv;
          w_rom_addr_nxt = i_req_addr[3*int'(w_winner) +: 3];
          w_left_nxt     = i_req_len[3*int'(w_winner) +: 3];
          w_rom_sel_nxt  = 1'b1;
        end
      end
      ST_BURST: begin
        w_rd_valid_nxt = 1'b1;
        w_rd_data_nxt  = i_rom_data;
        w_rd_id_nxt    = r_owner;
        w_rd_last_nxt  = (r_left == 3'd0);
        if (r_left != 3'd0) begin
          w_rom_sel_nxt  = 1'b1;
          w_rom_addr_nxt = r_rom_addr + 3'd1;
          w_left_nxt     = r_left - 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign o_gnt      = r_gnt;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_id    = r_rd_id;
  assign o_rd_last  = r_rd_last;
  assign o_rom_addr = r_rom_addr;
  assign o_rom_sel  = r_rom_sel;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
//   Directed bench for rom_arbiter with NREQ=2 and an 8x8 ROM model.

module tb_rom_arbiter;
  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req;
  logic [5:0]      req_addr;
  logic [5:0]      req_len;
  logic [1:0]      gnt;
  logic            rd_valid;
  logic [7:0]      rd_data;
  logic [0:0]      rd_id;
  logic            rd_last;
  logic [2:0]      rom_addr;
  logic            rom_sel;
  logic [7:0]      rom_data;
  logic [7:0]      rom_mem [8];
  logic [7:0]      exp_w [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_sel ? rom_mem[rom_addr] : 8'h00;

  rom_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_addr(req_addr),
    .i_req_len(req_len), .o_gnt(gnt), .o_rd_valid(rd_valid),
    .o_rd_data(rd_data), .o_rd_id(rd_id), .o_rd_last(rd_last),
    .o_rom_addr(rom_addr), .o_rom_sel(rom_sel), .i_rom_data(rom_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0;
    tick(); tick();
    n_checks++;
    if ({gnt, rd_valid, rd_last, rom_sel} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt/valid/last/sel=%b expected 00000", {gnt, rd_valid, rd_last, rom_sel});
    end
    n_checks++;
    if ({rd_data, rd_id, rom_addr} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_data: data=%h id=%0d addr=%0d expected 0", rd_data, rd_id, rom_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req_addr[2:0] = 3'd3; req_len[2:0] = 3'd0; req = 2'b01;
    tick();
    n_checks++;
    if ({gnt, rom_sel, rom_addr, rd_valid} !== {2'b01, 1'b1, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL single_issue: gnt=%b sel=%b addr=%0d valid=%b expected 01 1 3 0", gnt, rom_sel, rom_addr, rd_valid);
    end
    req = 2'b00;
    tick();
    n_checks++;
    if ({gnt, rom_sel, rd_valid, rd_last, rd_id, rd_data} !== {2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h31}) begin
      n_fail++;
      $display("FAIL single_data: gnt=%b sel=%b valid=%b last=%b id=%0d data=%h expected 01 0 1 1 0 31",
               gnt, rom_sel, rd_valid, rd_last, rd_id, rd_data);
    end
    tick();
    n_checks++;
    if ({gnt, rd_valid, rd_last, rom_sel, rd_data} !== {2'b00, 3'b000, 8'h31}) begin
      n_fail++;
      $display("FAIL single_after: gnt=%b valid=%b last=%b sel=%b data=%h expected 00 0 0 0 31",
               gnt, rd_valid, rd_last, rom_sel, rd_data);
    end
  endtask

  task automatic test_wrap_burst();
    logic [2:0] ea;
    exp_w[0] = 8'h41; exp_w[1] = 8'h81; exp_w[2] = 8'hE1; exp_w[3] = 8'h03;
    req_addr[5:3] = 3'd6; req_len[5:3] = 3'd3; req = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      ea = 3'(6 + c - 1);
      n_checks++;
      if ({gnt, rom_sel, rd_valid} !== {2'b10, (c <= 4), (c >= 2)}) begin
        n_fail++;
        $display("FAIL wrap_ctrl c=%0d: gnt=%b sel=%b valid=%b", c, gnt, rom_sel, rd_valid);
      end
      if (c <= 4) begin
        n_checks++;
        if (rom_addr !== ea) begin
          n_fail++;
          $display("FAIL wrap_addr c=%0d: addr=%0d expected %0d", c, rom_addr, ea);
        end
      end
      if (c >= 2) begin
        n_checks++;
        if ({rd_data, rd_id, rd_last} !== {exp_w[c-2], 1'b1, (c == 5)}) begin
          n_fail++;
          $display("FAIL wrap_data c=%0d: data=%h id=%0d last=%b expected %h 1 %b", c, rd_data, rd_id, rd_last, exp_w[c-2], (c == 5));
        end
      end
      if (c == 5) req = 2'b00;
    end
    tick();
    n_checks++;
    if ({gnt, rd_valid, rom_sel} !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_end: gnt=%b valid=%b sel=%b expected 00 0 0", gnt, rd_valid, rom_sel);
    end
  endtask

  task automatic test_full_burst();
    exp_w[0] = 8'hE1; exp_w[1] = 8'h03; exp_w[2] = 8'h09; exp_w[3] = 8'h31;
    exp_w[4] = 8'h71; exp_w[5] = 8'h39; exp_w[6] = 8'h41; exp_w[7] = 8'h81;
    req_addr[2:0] = 3'd0; req_len[2:0] = 3'd7; req = 2'b01;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_checks++;
      if ({gnt, rom_sel, rd_valid} !== {2'b01, (c <= 8), (c >= 2)}) begin
        n_fail++;
        $display("FAIL full_ctrl c=%0d: gnt=%b sel=%b valid=%b", c, gnt, rom_sel, rd_valid);
      end
      if (c >= 2) begin
        n_checks++;
        if ({rd_data, rd_id, rd_last} !== {exp_w[c-2], 1'b0, (c == 9)}) begin
          n_fail++;
          $display("FAIL full_data c=%0d: data=%h id=%0d last=%b expected %h 0 %b", c, rd_data, rd_id, rd_last, exp_w[c-2], (c == 9));
        end
      end
      if (c == 9) req = 2'b00;
    end
    tick();
  endtask

  task automatic test_owner_drop();
    exp_w[0] = 8'h03; exp_w[1] = 8'h09; exp_w[2] = 8'h31; exp_w[3] = 8'h71;
    req_addr[5:3] = 3'd1; req_len[5:3] = 3'd3; req = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) req = 2'b00;
      n_checks++;
      if ({gnt, rom_sel, rd_valid} !== {2'b10, (c <= 4), (c >= 2)}) begin
        n_fail++;
        $display("FAIL drop_ctrl c=%0d: gnt=%b sel=%b valid=%b", c, gnt, rom_sel, rd_valid);
      end
      if (c >= 2) begin
        n_checks++;
        if ({rd_data, rd_id, rd_last} !== {exp_w[c-2], 1'b1, (c == 5)}) begin
          n_fail++;
          $display("FAIL drop_data c=%0d: data=%h id=%0d last=%b expected %h 1 %b", c, rd_data, rd_id, rd_last, exp_w[c-2], (c == 5));
        end
      end
    end
    tick();
  endtask

  task automatic test_contention();
    int owner;
    rst_n = 1'b0;
    req_addr = {3'd4, 3'd2}; req_len = 6'd0; req = 2'b11;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      owner = (c / 2) % 2;
      n_checks++;
      if ({gnt, rom_sel, rd_valid} !== {(owner == 1) ? 2'b10 : 2'b01, (c % 2 == 0), (c % 2 == 1)}) begin
        n_fail++;
        $display("FAIL cont_ctrl c=%0d: gnt=%b sel=%b valid=%b owner=%0d", c, gnt, rom_sel, rd_valid, owner);
      end
      if (c % 2 == 1) begin
        n_checks++;
        if ({rd_id, rd_last, rd_data} !== {1'(owner), 1'b1, (owner == 1) ? 8'h71 : 8'h09}) begin
          n_fail++;
          $display("FAIL cont_data c=%0d: id=%0d last=%b data=%h owner=%0d", c, rd_id, rd_last, rd_data, owner);
        end
      end
      if (c == 6) req = 2'b00;
    end
    tick();
    n_checks++;
    if ({gnt, rom_sel, rd_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL cont_end: gnt=%b sel=%b valid=%b expected 00 0 0", gnt, rom_sel, rd_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    req_addr[2:0] = 3'd0; req_len[2:0] = 3'd7; req = 2'b01;
    tick();
    req = 2'b00;
    tick(); tick(); tick();
    n_checks++;
    if ({rd_valid, rd_data, gnt} !== {1'b1, 8'h09, 2'b01}) begin
      n_fail++;
      $display("FAIL mid_word2: valid=%b data=%h gnt=%b expected 1 09 01", rd_valid, rd_data, gnt);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({gnt, rd_valid, rd_last, rom_sel, rd_id, rd_data, rom_addr} !== 17'h0) begin
      n_fail++;
      $display("FAIL mid_reset: gnt=%b valid=%b last=%b sel=%b id=%0d data=%h addr=%0d expected all 0",
               gnt, rd_valid, rd_last, rom_sel, rd_id, rd_data, rom_addr);
    end
    req_len = 6'd0; req = 2'b11;
    tick();
    n_checks++;
    if ({rd_valid, rom_sel} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_hold: valid=%b sel=%b expected 0 0", rd_valid, rom_sel);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({gnt, rom_sel} !== 3'b011) begin
      n_fail++;
      $display("FAIL mid_ptr: gnt=%b sel=%b expected 01 1", gnt, rom_sel);
    end
    req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    rom_mem[0] = 8'hE1; rom_mem[1] = 8'h03; rom_mem[2] = 8'h09; rom_mem[3] = 8'h31;
    rom_mem[4] = 8'h71; rom_mem[5] = 8'h39; rom_mem[6] = 8'h41; rom_mem[7] = 8'h81;
    test_reset();
    test_single_read();
    test_wrap_burst();
    test_full_burst();
    test_owner_drop();
    test_contention();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
